dpwm_soft_start_ctrl: RTL and testbench

//  Sequencer that drives the dpwm i_ton/enable inputs. On enable it starts the PWM at TON_MIN,

---
 rtl/dpwm_soft_start_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dpwm_soft_start_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_soft_start_ctrl.sv
// Soft-start sequencer for the dpwm: starts the PWM at TON_MIN on enable and
// rate-limits ton toward the target, one step every STEP_PERIODS switching
// periods. Any fault is latched and forces the PWM off.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   enable       run request (level)
//   i_ton_target requested steady-state ton (from the duty selector)
//   i_step       ton change per ramp step (0 is treated as 1)
//   i_ts_last    1-cycle strobe on the last clk of a switching period
//   i_fault      fault input (level)
//   o_ton        ton to dpwm i_ton
//   o_dpwm_en    enable to dpwm
//   o_ss_done    high while the ramp has settled (RUN)
//   o_fault      latched fault flag
module dpwm_soft_start_ctrl #(
    parameter int unsigned TON_W        = 11,
    parameter int unsigned TON_MIN      = 8,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [TON_W-1:0] i_ton_target,
    input  logic [3:0]       i_step,
    input  logic             i_ts_last,
    input  logic             i_fault,
    output logic [TON_W-1:0] o_ton,
    output logic             o_dpwm_en,
    output logic             o_ss_done,
    output logic             o_fault
);

    localparam logic [TON_W-1:0] TON_MIN_W = TON_W'(TON_MIN);
    localparam logic [TON_W-1:0] TON_MAX_W = {TON_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           r_state;
    logic [TON_W-1:0] r_ton;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dpwm_en;
    logic             r_ss_done;
    logic             r_fault;

    state_t           w_state_nxt;
    logic [TON_W-1:0] w_ton_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dpwm_en_nxt;
    logic             w_ss_done_nxt;
    logic             w_fault_nxt;

    logic [TON_W-1:0] w_tgt;
    logic [TON_W-1:0] w_step;
    logic [TON_W:0]   w_sum;
    logic [TON_W-1:0] w_sum_sat;
    logic [TON_W-1:0] w_ton_up;
    logic [TON_W-1:0] w_ton_down;
    logic [TON_W-1:0] w_ton_stepped;

    // Target clamped to the floor, step with 0 mapped to 1
    assign w_tgt  = (i_ton_target < TON_MIN_W) ? TON_MIN_W : i_ton_target;
    assign w_step = (i_step == 4'd0) ? TON_W'(1) : TON_W'(i_step);

    // Upward move: widened sum, saturate, then clamp to target
    assign w_sum     = {1'b0, r_ton} + {1'b0, w_step};
    assign w_sum_sat = w_sum[TON_W] ? TON_MAX_W : w_sum[TON_W-1:0];
    assign w_ton_up  = (w_sum_sat > w_tgt) ? w_tgt : w_sum_sat;

    // Downward move: compare the gap first so the subtraction never wraps
    assign w_ton_down = ((r_ton - w_tgt) <= w_step) ? w_tgt : (r_ton - w_step);

    assign w_ton_stepped = (r_ton < w_tgt) ? w_ton_up :
                           (r_ton > w_tgt) ? w_ton_down : r_ton;

    // Next-state and registered-output values; fault > disable > ramp step
    always_comb begin
        w_state_nxt   = r_state;
        w_ton_nxt     = r_ton;
        w_cnt_nxt     = r_cnt;
        w_dpwm_en_nxt = r_dpwm_en;
        w_ss_done_nxt = r_ss_done;
        w_fault_nxt   = r_fault;

        if (i_fault) begin
            w_state_nxt   = S_FAULT;
            w_ton_nxt     = TON_MIN_W;
            w_cnt_nxt     = '0;
            w_dpwm_en_nxt = 1'b0;
            w_ss_done_nxt = 1'b0;
            w_fault_nxt   = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_ton_nxt     = TON_MIN_W;
                    w_dpwm_en_nxt = 1'b0;
                    w_ss_done_nxt = 1'b0;
                    if (enable) begin
                        w_state_nxt   = S_RAMP;
                        w_dpwm_en_nxt = 1'b1;
                        w_cnt_nxt     = '0;
                    end
                end
                S_RAMP, S_RUN: begin
                    if (!enable) begin
                        w_state_nxt   = S_IDLE;
                        w_ton_nxt     = TON_MIN_W;
                        w_cnt_nxt     = '0;
                        w_dpwm_en_nxt = 1'b0;
                        w_ss_done_nxt = 1'b0;
                    end else if (i_ts_last) begin
                        if (r_cnt == CNT_LAST) begin
                            w_cnt_nxt = '0;
                            w_ton_nxt = w_ton_stepped;
                            // Once settled, RUN is held even while tracking a new target
                            if (w_ton_stepped == w_tgt) begin
                                w_state_nxt   = S_RUN;
                                w_ss_done_nxt = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FAULT: begin
                    if (!enable) begin
                        w_state_nxt = S_IDLE;
                        w_fault_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ton     <= TON_MIN_W;
            r_cnt     <= '0;
            r_dpwm_en <= 1'b0;
            r_ss_done <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ton     <= w_ton_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dpwm_en <= w_dpwm_en_nxt;
            r_ss_done <= w_ss_done_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign o_ton     = r_ton;
    assign o_dpwm_en = r_dpwm_en;
    assign o_ss_done = r_ss_done;
    assign o_fault   = r_fault;

endmodule

// File: tb/tb_dpwm_soft_start_ctrl.sv
// Testbench for dpwm_soft_start_ctrl: directed scenarios followed by random
// stimulus, all checked every cycle against a behavioural model.
module tb_dpwm_soft_start_ctrl;

    localparam int TON_W        = 11;
    localparam int TON_MIN      = 8;
    localparam int STEP_PERIODS = 4;
    localparam int TON_MAXV     = (1 << TON_W) - 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [TON_W-1:0]  i_ton_target;
    logic [3:0]        i_step;
    logic              i_ts_last;
    logic              i_fault;
    logic [TON_W-1:0]  o_ton;
    logic              o_dpwm_en;
    logic              o_ss_done;
    logic              o_fault;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 off, 1 ramping, 2 settled, 3 faulted
    int m_mode;
    int m_ton;
    int m_periods;
    int m_en;
    int m_done;
    int m_flt;

    dpwm_soft_start_ctrl #(
        .TON_W(TON_W), .TON_MIN(TON_MIN), .STEP_PERIODS(STEP_PERIODS), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_ton_target(i_ton_target),
        .i_step(i_step), .i_ts_last(i_ts_last), .i_fault(i_fault),
        .o_ton(o_ton), .o_dpwm_en(o_dpwm_en), .o_ss_done(o_ss_done), .o_fault(o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ton = TON_MIN; m_periods = 0; m_en = 0; m_done = 0; m_flt = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        int tgt, stp;
        tgt = (int'(i_ton_target) < TON_MIN) ? TON_MIN : int'(i_ton_target);
        stp = (i_step == 0) ? 1 : int'(i_step);
        if (i_fault) begin
            m_mode = 3; m_ton = TON_MIN; m_periods = 0; m_en = 0; m_done = 0; m_flt = 1;
        end else if (m_mode == 0) begin
            if (enable) begin m_mode = 1; m_en = 1; m_periods = 0; end
        end else if (m_mode == 3) begin
            if (!enable) begin m_mode = 0; m_flt = 0; end
        end else if (!enable) begin
            m_mode = 0; m_ton = TON_MIN; m_periods = 0; m_en = 0; m_done = 0;
        end else if (i_ts_last) begin
            m_periods++;
            if (m_periods == STEP_PERIODS) begin
                m_periods = 0;
                if (m_ton < tgt) begin
                    m_ton = m_ton + stp;
                    if (m_ton > TON_MAXV) m_ton = TON_MAXV;
                    if (m_ton > tgt) m_ton = tgt;
                end else if (m_ton > tgt) begin
                    m_ton = m_ton - stp;
                    if (m_ton < tgt) m_ton = tgt;
                end
                if (m_ton == tgt) begin m_mode = 2; m_done = 1; end
            end
        end
    endtask

    task automatic cmp_all();
        chk("ton", int'(o_ton), m_ton);
        chk("dpwm_en", int'(o_dpwm_en), m_en);
        chk("ss_done", int'(o_ss_done), m_done);
        chk("fault", int'(o_fault), m_flt);
    endtask

    // One clock: edge, model update, sample 1ns later
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic cyc_ts();
        i_ts_last = 1'b1;
        cyc();
        i_ts_last = 1'b0;
    endtask

    // n switching periods of len clocks each
    task automatic periods(input int n, input int len);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < len - 1; k++) cyc();
            cyc_ts();
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; i_ton_target = '0; i_step = 4'd4;
        i_ts_last = 1'b0; i_fault = 1'b0;
        model_reset();
        #12;
        chk("rst_ton", int'(o_ton), TON_MIN);
        chk("rst_en", int'(o_dpwm_en), 0);
        chk("rst_done", int'(o_ss_done), 0);
        chk("rst_fault", int'(o_fault), 0);
        rst = 1'b1;
        cyc();

        // Ramp 8 -> 40 in steps of 4, ts_last every 100 clk
        i_ton_target = 11'd40; i_step = 4'd4; enable = 1'b1;
        cyc();
        chk("t1_en_after_1clk", int'(o_dpwm_en), 1);
        periods(STEP_PERIODS - 1, 100);
        chk("t1_ton_hold", int'(o_ton), 8);
        periods(1, 100);
        chk("t1_ton_first_step", int'(o_ton), 12);
        periods(7 * STEP_PERIODS, 100);
        chk("t1_ton_final", int'(o_ton), 40);
        chk("t1_done", int'(o_ss_done), 1);

        // Fresh ramp to 42: last step clamps 40 -> 42
        enable = 1'b0; cyc(); enable = 1'b1;
        i_ton_target = 11'd42;
        periods(9 * STEP_PERIODS - 1, 10);
        chk("t2_ton_pre", int'(o_ton), 40);
        chk("t2_done_pre", int'(o_ss_done), 0);
        periods(1, 10);
        chk("t2_ton_clamp", int'(o_ton), 42);
        chk("t2_done", int'(o_ss_done), 1);

        // In RUN: back to 40, then down to 20 with step 8
        i_ton_target = 11'd40;
        periods(STEP_PERIODS, 10);
        chk("t3_ton_40", int'(o_ton), 40);
        i_ton_target = 11'd20; i_step = 4'd8;
        periods(STEP_PERIODS, 10);
        chk("t3_ton_32", int'(o_ton), 32);
        periods(STEP_PERIODS, 10);
        chk("t3_ton_24", int'(o_ton), 24);
        periods(STEP_PERIODS, 10);
        chk("t3_ton_20", int'(o_ton), 20);
        chk("t3_done", int'(o_ss_done), 1);

        // Fault mid-ramp, held while enabled, cleared by disable
        enable = 1'b0; cyc(); enable = 1'b1; i_ton_target = 11'd100; i_step = 4'd4;
        periods(2 * STEP_PERIODS, 10);
        i_fault = 1'b1; cyc(); i_fault = 1'b0;
        chk("t4_fault", int'(o_fault), 1);
        chk("t4_ton", int'(o_ton), TON_MIN);
        periods(2, 10);
        chk("t4_fault_held", int'(o_fault), 1);
        enable = 1'b0; cyc();
        chk("t4_fault_clr", int'(o_fault), 0);

        // Fault coincident with a step boundary
        enable = 1'b1;
        periods(STEP_PERIODS - 1, 10);
        for (int k = 0; k < 9; k++) cyc();
        i_fault = 1'b1; cyc_ts(); i_fault = 1'b0;
        chk("t5_fault_wins_ton", int'(o_ton), TON_MIN);
        chk("t5_fault_wins_flt", int'(o_fault), 1);
        enable = 1'b0; cyc();

        // Target below floor: RUN at first boundary, ton unchanged
        enable = 1'b1; i_ton_target = 11'd3;
        periods(STEP_PERIODS, 10);
        chk("t5_low_tgt_done", int'(o_ss_done), 1);
        chk("t5_low_tgt_ton", int'(o_ton), TON_MIN);

        // Step 0 acts as 1, then async reset mid-ramp
        i_ton_target = 11'd12; i_step = 4'd0;
        periods(STEP_PERIODS, 10);
        chk("t6_step0", int'(o_ton), 9);
        periods(STEP_PERIODS, 10);
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk("t6_arst_ton", int'(o_ton), TON_MIN);
        chk("t6_arst_en", int'(o_dpwm_en), 0);
        chk("t6_arst_done", int'(o_ss_done), 0);
        #2 rst = 1'b1;
        cyc();

        // Random phase
        enable = 1'b1; i_step = 4'd3; i_ton_target = 11'd60;
        for (int n = 0; n < 6000; n++) begin
            i_ts_last = ($urandom_range(0, 7) == 0);
            i_fault   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) i_ton_target = TON_W'($urandom_range(0, 200));
            if ($urandom_range(0, 99) == 0) i_step = 4'($urandom_range(0, 15));
            cyc();
        end
        i_ts_last = 1'b0; i_fault = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
